// File: rtl/switch_debounce.sv
// Multi-bit switch debouncer with 2-flop synchronizers, per-bit stability counters,
// rise/fall pulses and a single-entry change-event register with overflow flag.
module switch_debounce #(
  parameter int WIDTH     = 8,
  parameter int DB_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] switch,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             evt_valid,
  output logic [WIDTH-1:0] evt_data,
  input  logic             evt_ready,
  output logic             evt_ovf
);

  // State table
  //   ST_IDLE | no event pending, evt_ready ignored
  //   ST_PEND | snapshot held in evt_data, waiting for evt_ready

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DB_CYCLES - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] clean_q;
  logic [WIDTH-1:0] clean_d;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             upd;
  logic             hs;

  // Counter runs only while the synchronized level disagrees with sw_clean;
  // reaching the terminal count with the level still different commits it.
  always_comb begin
    clean_d = clean_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != clean_q[i]) begin
        if (cnt_q[i] == CNT_TC) begin
          clean_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= switch;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      rise_q  <= clean_d & ~clean_q;
      fall_q  <= ~clean_d & clean_q;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Event tracking keys off clean_d so the event lands on the same edge as sw_clean.
  assign upd = |(clean_d ^ clean_q);
  assign hs  = (state_q == ST_PEND) && evt_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (upd) begin
          state_d = ST_PEND;
          data_d  = clean_d;
          ovf_d   = 1'b0;
        end
      end
      ST_PEND: begin
        if (upd) begin
          data_d = clean_d;
          ovf_d  = !hs;
        end else if (hs) begin
          state_d = ST_IDLE;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ovf_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sw_clean  = clean_q;
  assign sw_rise   = rise_q;
  assign sw_fall   = fall_q;
  assign evt_valid = (state_q == ST_PEND);
  assign evt_data  = data_q;
  assign evt_ovf   = ovf_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Randomized and directed bench for switch_debounce; a sample-history reference model
// decides each clean level from the last DB_CYCLES synchronized samples.
module tb_switch_debounce;

  localparam int WIDTH = 8;
  localparam int DB    = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] switch;
  logic [WIDTH-1:0] sw_clean;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             evt_valid;
  logic [WIDTH-1:0] evt_data;
  logic             evt_ready;
  logic             evt_ovf;

  switch_debounce #(.WIDTH(WIDTH), .DB_CYCLES(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .switch    (switch),
    .sw_clean  (sw_clean),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .evt_valid (evt_valid),
    .evt_data  (evt_data),
    .evt_ready (evt_ready),
    .evt_ovf   (evt_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Model state: samples taken at each edge (0 during reset), plus expected outputs.
  logic [WIDTH-1:0] hist [$];
  logic [WIDTH-1:0] m_clean;
  logic [WIDTH-1:0] m_rise;
  logic [WIDTH-1:0] m_fall;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ovf;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // A bit becomes v once its last DB samples (ignoring the two synchronizer stages) are all v.
  task automatic model_edge(input logic [WIDTH-1:0] sw, input logic r, input logic rdy);
    logic [WIDTH-1:0] all1;
    logic [WIDTH-1:0] any1;
    logic [WIDTH-1:0] nxt;
    logic             change;
    int               last;
    hist.push_back(r ? '0 : sw);
    while (hist.size() > DB + 4) void'(hist.pop_front());
    if (r) begin
      m_clean = '0;
      m_rise  = '0;
      m_fall  = '0;
      m_valid = 1'b0;
      m_data  = '0;
      m_ovf   = 1'b0;
    end else begin
      last = hist.size() - 1;
      all1 = '1;
      any1 = '0;
      for (int k = last - DB - 1; k <= last - 2; k++) begin
        all1 &= hist[k];
        any1 |= hist[k];
      end
      nxt    = all1 | (m_clean & any1);
      change = (nxt != m_clean);
      m_rise = nxt & ~m_clean;
      m_fall = ~nxt & m_clean;
      if (m_valid) begin
        if (change) begin
          m_data = nxt;
          m_ovf  = !rdy;
        end else if (rdy) begin
          m_valid = 1'b0;
          m_ovf   = 1'b0;
        end
      end else if (change) begin
        m_valid = 1'b1;
        m_data  = nxt;
        m_ovf   = 1'b0;
      end
      m_clean = nxt;
    end
  endtask

  task automatic step(input logic [WIDTH-1:0] sw, input logic r, input logic rdy);
    switch    = sw;
    rst       = r;
    evt_ready = rdy;
    @(posedge clk);
    model_edge(sw, r, rdy);
    #1;
    chk("sw_clean", 32'(sw_clean), 32'(m_clean));
    chk("sw_rise", 32'(sw_rise), 32'(m_rise));
    chk("sw_fall", 32'(sw_fall), 32'(m_fall));
    chk("evt_valid", 32'(evt_valid), 32'(m_valid));
    chk("evt_data", 32'(evt_data), 32'(m_data));
    chk("evt_ovf", 32'(evt_ovf), 32'(m_ovf));
  endtask

  initial begin
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] gl;
    int               rst_cnt;
    n_vec     = 0;
    n_err     = 0;
    switch    = '0;
    rst       = 1'b1;
    evt_ready = 1'b0;
    m_clean   = '0;
    m_rise    = '0;
    m_fall    = '0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_ovf     = 1'b0;
    for (int i = 0; i < DB + 2; i++) hist.push_back('0);
    #2;

    // Switches high through reset: five quiet edges, then everything lands on the sixth.
    for (int i = 0; i < 3; i++) step(8'hFF, 1'b1, 1'b0);
    chk("rst_clean", 32'(sw_clean), 32'h0);
    chk("rst_valid", 32'(evt_valid), 32'h0);
    for (int i = 0; i < DB + 1; i++) begin
      step(8'hFF, 1'b0, 1'b0);
      chk("rel_hold", 32'(sw_clean), 32'h0);
    end
    step(8'hFF, 1'b0, 1'b0);
    chk("rel_clean", 32'(sw_clean), 32'hFF);
    chk("rel_rise", 32'(sw_rise), 32'hFF);
    chk("rel_valid", 32'(evt_valid), 32'h1);
    chk("rel_data", 32'(evt_data), 32'hFF);
    step(8'hFF, 1'b0, 1'b0);
    chk("rel_rise_once", 32'(sw_rise), 32'h0);
    step(8'hFF, 1'b0, 1'b1);
    chk("rel_ack", 32'(evt_valid), 32'h0);

    // Short glitch on bit0 from a clean 00 state.
    for (int i = 0; i < 2; i++) step(8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(8'h00, 1'b0, 1'b0);
      chk("glitch_clean", 32'(sw_clean), 32'h0);
      chk("glitch_valid", 32'(evt_valid), 32'h0);
    end

    // Update while pending and unacknowledged merges into the event.
    for (int i = 0; i < DB + 2; i++) step(8'h01, 1'b0, 1'b0);
    chk("pend_data", 32'(evt_data), 32'h01);
    for (int i = 0; i < DB + 2; i++) step(8'h03, 1'b0, 1'b0);
    chk("ovf_data", 32'(evt_data), 32'h03);
    chk("ovf_flag", 32'(evt_ovf), 32'h1);
    step(8'h03, 1'b0, 1'b1);
    chk("ovf_ack_valid", 32'(evt_valid), 32'h0);
    chk("ovf_ack_flag", 32'(evt_ovf), 32'h0);

    // Update coinciding with a handshake keeps the event pending.
    for (int i = 0; i < DB + 2; i++) step(8'h13, 1'b0, 1'b0);
    for (int i = 0; i < DB + 1; i++) step(8'h17, 1'b0, 1'b0);
    step(8'h17, 1'b0, 1'b1);
    chk("coin_valid", 32'(evt_valid), 32'h1);
    chk("coin_data", 32'(evt_data), 32'h17);
    chk("coin_ovf", 32'(evt_ovf), 32'h0);
    step(8'h17, 1'b0, 1'b1);

    // Reset in the middle of a bit3 count, then a full re-debounce.
    for (int i = 0; i < 4; i++) step(8'h1F, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(8'h1F, 1'b1, 1'b0);
    for (int i = 0; i < DB + 1; i++) begin
      step(8'h1F, 1'b0, 1'b0);
      chk("abort_hold", 32'(sw_clean), 32'h0);
      chk("abort_rise", 32'(sw_rise), 32'h0);
    end
    step(8'h1F, 1'b0, 1'b0);
    chk("abort_redeb", 32'(sw_clean), 32'h1F);

    // Random bouncy switches, random consumer, occasional resets.
    tgt     = 8'h1F;
    rst_cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 9) == 0) tgt ^= WIDTH'(1) << $urandom_range(0, WIDTH - 1);
      if ($urandom_range(0, 59) == 0) tgt ^= WIDTH'($urandom);
      gl = ($urandom_range(0, 5) == 0) ? (WIDTH'(1) << $urandom_range(0, WIDTH - 1)) : '0;
      if (rst_cnt == 0 && $urandom_range(0, 599) == 0) rst_cnt = 2 + $urandom_range(0, 2);
      step(tgt ^ gl, rst_cnt != 0, $urandom_range(0, 2) == 0);
      if (rst_cnt != 0) rst_cnt--;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
